// File: rtl/mem_responder_pkg.sv
// Shared encodings for the memory responder: access sizes, FSM states, lane count.
package mem_pkg;
    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;
    localparam int         LANES   = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_RESP
    } state_t;
endpackage

// File: rtl/mem_responder_if.sv
// Request/response handshake bundle between the CPU memory mux and the responder.
interface mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_addr, req_wdata, req_we, req_size, req_unsigned, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );
    modport slave (
        input  req_valid, req_addr, req_wdata, req_we, req_size, req_unsigned, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/mem_responder_lane_align.sv
// Little-endian lane steering: write mask/replicated write word, read extraction
// with sign/zero extension, and alignment/size legality.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]       addr_lo,
    input  logic [1:0]       size,
    input  logic             is_unsigned,
    input  logic [31:0]      wdata,
    input  logic [31:0]      rdword,
    output logic [LANES-1:0] wmask,
    output logic [31:0]      wword,
    output logic [31:0]      rdata,
    output logic             misalign
);
    logic [15:0] half_sel;
    logic [7:0]  byte_sel;

    always_comb begin
        wmask    = '0;
        wword    = '0;
        rdata    = '0;
        misalign = 1'b0;
        half_sel = addr_lo[1] ? rdword[31:16] : rdword[15:0];
        byte_sel = rdword[{addr_lo, 3'b000} +: 8];
        case (size)
            SZ_WORD: begin
                wmask    = 4'b1111;
                wword    = wdata;
                rdata    = rdword;
                misalign = (addr_lo != 2'b00);
            end
            SZ_HALF: begin
                wmask    = addr_lo[1] ? 4'b1100 : 4'b0011;
                wword    = {2{wdata[15:0]}};
                rdata    = is_unsigned ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
                misalign = addr_lo[0];
            end
            SZ_BYTE: begin
                wmask    = 4'b0001 << addr_lo;
                wword    = {4{wdata[7:0]}};
                rdata    = is_unsigned ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            end
            default: misalign = 1'b1;  // size 11 is reported through the same error path
        endcase
    end
endmodule

// File: rtl/mem_responder.sv
// Handshaked single-outstanding memory slave with programmable wait states over a
// word-organised array; registered response with alignment and error reporting.
module mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2,
    parameter int CNT_W       = 8
) (
    input  logic            clk,
    input  logic            rst,
    mem_responder_if.slave  bus
);
    localparam int              AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic [31:0]       addr_q, addr_d, wdata_q, wdata_d, rd_word_q;
    logic              we_q, we_d, uns_q, uns_d;
    logic [1:0]        size_q, size_d;

    logic [31:0]       mem [DEPTH_WORDS];
    logic [LANES-1:0]  wmask;
    logic [31:0]       wword, rdata_al;
    logic              misalign, in_range, access_err, req_ready;

    mem_lane_align u_align (
        .addr_lo     (addr_q[1:0]),
        .size        (size_q),
        .is_unsigned (uns_q),
        .wdata       (wdata_q),
        .rdword      (rd_word_q),
        .wmask       (wmask),
        .wword       (wword),
        .rdata       (rdata_al),
        .misalign    (misalign)
    );

    assign in_range   = {2'b00, addr_q[31:2]} < 32'(DEPTH_WORDS);
    assign access_err = misalign || !in_range;
    assign req_ready  = (state_q == S_IDLE) && rst;

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        size_d      = size_q;
        uns_d       = uns_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid && req_ready) begin
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    we_d    = bus.req_we;
                    size_d  = bus.req_size;
                    uns_d   = bus.req_unsigned;
                    if (WAIT_CYCLES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_LOAD;
                    end else begin
                        state_d = S_ACCESS;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) state_d = S_ACCESS;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_ACCESS: begin
                err_d   = access_err;
                state_d = S_RESP;
            end
            default: begin
                // First RESP cycle waits for the synchronous array read, then presents.
                if (!rsp_valid_q) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = err_q;
                    rsp_rdata_d = (err_q || we_q) ? 32'b0 : rdata_al;
                end else if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
                    state_d     = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    always_ff @(posedge clk) begin
        addr_q    <= addr_d;
        wdata_q   <= wdata_d;
        we_q      <= we_d;
        size_q    <= size_d;
        uns_q     <= uns_d;
        rd_word_q <= mem[addr_q[AW+1:2]];
        if (state_q == S_ACCESS && we_q && !access_err) begin
            for (int i = 0; i < LANES; i++) begin
                if (wmask[i]) mem[addr_q[AW+1:2]][8*i +: 8] <= wword[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: WAIT_CYCLES=2 and WAIT_CYCLES=0 instances against a
// byte-addressed reference memory model.
module tb_mem_responder;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [7:0] mdl [2][4096];

    always #5 clk = ~clk;

    mem_responder_if bus_w2 ();
    mem_responder_if bus_w0 ();

    mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2), .CNT_W(8)) u_w2 (
        .clk(clk), .rst(rst), .bus(bus_w2.slave));
    mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0), .CNT_W(8)) u_w0 (
        .clk(clk), .rst(rst), .bus(bus_w0.slave));

    function automatic logic rdy(input int sel);
        return (sel == 0) ? bus_w2.req_ready : bus_w0.req_ready;
    endfunction
    function automatic logic rv(input int sel);
        return (sel == 0) ? bus_w2.rsp_valid : bus_w0.rsp_valid;
    endfunction
    function automatic logic [31:0] rd(input int sel);
        return (sel == 0) ? bus_w2.rsp_rdata : bus_w0.rsp_rdata;
    endfunction
    function automatic logic re(input int sel);
        return (sel == 0) ? bus_w2.rsp_err : bus_w0.rsp_err;
    endfunction
    function automatic int exp_lat(input int sel);
        return (sel == 0) ? 4 : 2;
    endfunction

    task automatic set_req(input int sel, input logic v, input logic [31:0] a, input logic we,
                           input logic [1:0] sz, input logic uns, input logic [31:0] wd);
        if (sel == 0) begin
            bus_w2.req_valid = v; bus_w2.req_addr = a; bus_w2.req_we = we;
            bus_w2.req_size = sz; bus_w2.req_unsigned = uns; bus_w2.req_wdata = wd;
        end else begin
            bus_w0.req_valid = v; bus_w0.req_addr = a; bus_w0.req_we = we;
            bus_w0.req_size = sz; bus_w0.req_unsigned = uns; bus_w0.req_wdata = wd;
        end
    endtask

    task automatic set_rsp_ready(input int sel, input logic r);
        if (sel == 0) bus_w2.rsp_ready = r;
        else          bus_w0.rsp_ready = r;
    endtask

    // Reference: byte-addressed little-endian memory; sizes 4/2/1 bytes, natural alignment.
    task automatic model_txn(input int sel, input logic [31:0] a, input logic we,
                             input logic [1:0] sz, input logic uns, input logic [31:0] wd,
                             output logic [31:0] erd, output logic eer);
        int n;
        logic [31:0] v;
        n   = (sz == 2'd0) ? 4 : (sz == 2'd1) ? 2 : 1;
        eer = (sz == 2'd3) || ((a % n) != 0) || ((a >> 2) >= 1024);
        erd = 32'h0;
        if (!eer) begin
            if (we) begin
                for (int i = 0; i < n; i++) mdl[sel][a + i] = wd[8*i +: 8];
            end else begin
                v = 32'h0;
                for (int i = 0; i < n; i++) v = v | (32'(mdl[sel][a + i]) << (8*i));
                if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
                erd = v;
            end
        end
    endtask

    // Waits for rsp_valid after an accept edge, counting edges; then completes the handshake.
    task automatic wait_rsp(input int sel, output int lat, output logic [31:0] r, output logic e);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!rv(sel) && lat < 50);
        r = rd(sel);
        e = re(sel);
        set_rsp_ready(sel, 1'b1);
        @(posedge clk); #1;
        set_rsp_ready(sel, 1'b0);
    endtask

    task automatic txn(input int sel, input logic [31:0] a, input logic we, input logic [1:0] sz,
                       input logic uns, input logic [31:0] wd,
                       output logic [31:0] r, output logic e, output int lat, output int waits);
        set_req(sel, 1'b1, a, we, sz, uns, wd);
        waits = 0;
        while (!rdy(sel) && waits < 50) begin
            @(posedge clk); #1;
            waits++;
        end
        @(posedge clk); #1;
        set_req(sel, 1'b0, $urandom, 1'($urandom), 2'($urandom), 1'($urandom), $urandom);
        wait_rsp(sel, lat, r, e);
    endtask

    // Full transaction checked against the model; returns the observed read data.
    task automatic run_check(input int sel, input string nm, input logic [31:0] a, input logic we,
                             input logic [1:0] sz, input logic uns, input logic [31:0] wd,
                             output logic [31:0] r);
        logic [31:0] erd;
        logic e, eer;
        int lat, waits;
        model_txn(sel, a, we, sz, uns, wd, erd, eer);
        txn(sel, a, we, sz, uns, wd, r, e, lat, waits);
        checks++;
        if (r !== erd || e !== eer) begin
            errors++;
            $display("FAIL %s dut%0d addr=%h: got rdata=%h err=%b, want rdata=%h err=%b",
                     nm, sel, a, r, e, erd, eer);
        end
        checks++;
        if (lat !== exp_lat(sel)) begin
            errors++;
            $display("FAIL %s_latency dut%0d: got %0d edges, want %0d", nm, sel, lat, exp_lat(sel));
        end
    endtask

    task automatic test_reset();
        #2;
        for (int s = 0; s < 2; s++) begin
            checks++;
            if (rdy(s) !== 1'b0 || rv(s) !== 1'b0 || rd(s) !== 32'h0 || re(s) !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs dut%0d: got ready=%b valid=%b rdata=%h err=%b, want 0 0 0 0",
                         s, rdy(s), rv(s), rd(s), re(s));
            end
        end
        @(posedge clk); @(negedge clk);
        rst = 1'b1;
        #1;
        for (int s = 0; s < 2; s++) begin
            checks++;
            if (rdy(s) !== 1'b1) begin
                errors++;
                $display("FAIL reset_release_ready dut%0d: got %b, want 1", s, rdy(s));
            end
        end
    endtask

    task automatic test_plan_directed();
        logic [31:0] r;
        run_check(0, "word_write", 32'h10, 1'b1, 2'b00, 1'b0, 32'hDEAD_BEEF, r);
        run_check(0, "word_read", 32'h10, 1'b0, 2'b00, 1'b0, 32'h0, r);
        checks++;
        if (r !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL word_read_const: got %h, want deadbeef", r);
        end
        run_check(0, "byte_write_7f", 32'h11, 1'b1, 2'b10, 1'b0, 32'hAAAA_AA7F, r);
        run_check(0, "byte_read_s_7f", 32'h11, 1'b0, 2'b10, 1'b0, 32'h0, r);
        run_check(0, "byte_write_80", 32'h12, 1'b1, 2'b10, 1'b0, 32'h5555_5580, r);
        run_check(0, "byte_read_s_80", 32'h12, 1'b0, 2'b10, 1'b0, 32'h0, r);
        checks++;
        if (r !== 32'hFFFF_FF80) begin
            errors++; $display("FAIL byte_sext_const: got %h, want ffffff80", r);
        end
        run_check(0, "byte_read_u_80", 32'h12, 1'b0, 2'b10, 1'b1, 32'h0, r);
        run_check(0, "word_read_merged", 32'h10, 1'b0, 2'b00, 1'b0, 32'h0, r);
        checks++;
        if (r !== 32'hDE80_7FEF) begin
            errors++; $display("FAIL merged_const: got %h, want de807fef", r);
        end
        run_check(0, "half_read_s", 32'h12, 1'b0, 2'b01, 1'b0, 32'h0, r);
        run_check(0, "half_misalign", 32'h13, 1'b0, 2'b01, 1'b0, 32'h0, r);
        run_check(0, "word_misalign", 32'h12, 1'b1, 2'b00, 1'b0, 32'h1111_1111, r);
        run_check(0, "illegal_size", 32'h10, 1'b0, 2'b11, 1'b0, 32'h0, r);
        run_check(0, "word1_write", 32'h4, 1'b1, 2'b00, 1'b0, 32'h0BAD_F00D, r);
        run_check(0, "out_of_range", 32'h4004, 1'b1, 2'b00, 1'b0, 32'hFFFF_FFFF, r);
        run_check(0, "word1_unchanged", 32'h4, 1'b0, 2'b00, 1'b0, 32'h0, r);
    endtask

    task automatic test_stall();
        logic [31:0] erd, erd2, snap, r;
        logic eer, eer2, e;
        int lat;
        model_txn(0, 32'h10, 1'b0, 2'b00, 1'b0, 32'h0, erd, eer);
        model_txn(0, 32'h11, 1'b0, 2'b10, 1'b1, 32'h0, erd2, eer2);
        set_req(0, 1'b1, 32'h10, 1'b0, 2'b00, 1'b0, 32'h0);
        @(posedge clk); #1;
        set_req(0, 1'b1, 32'h11, 1'b0, 2'b10, 1'b1, 32'h0);
        lat = 0;
        do begin @(posedge clk); #1; lat++; end while (!rv(0) && lat < 50);
        snap = rd(0);
        checks++;
        if (snap !== erd || lat !== 4) begin
            errors++; $display("FAIL stall_first: got %h lat %0d, want %h lat 4", snap, lat, erd);
        end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            checks++;
            if (rv(0) !== 1'b1 || rd(0) !== snap || rdy(0) !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold cyc%0d: got valid=%b rdata=%h ready=%b, want 1 %h 0",
                         c, rv(0), rd(0), rdy(0), snap);
            end
        end
        set_rsp_ready(0, 1'b1);
        @(posedge clk); #1;
        set_rsp_ready(0, 1'b0);
        checks++;
        if (rv(0) !== 1'b0 || rdy(0) !== 1'b1) begin
            errors++; $display("FAIL stall_after_hs: got valid=%b ready=%b, want 0 1", rv(0), rdy(0));
        end
        @(posedge clk); #1;
        set_req(0, 1'b0, 32'h0, 1'b0, 2'b00, 1'b0, 32'h0);
        wait_rsp(0, lat, r, e);
        checks++;
        if (r !== erd2 || e !== eer2 || lat !== 4) begin
            errors++;
            $display("FAIL stall_second: got %h err %b lat %0d, want %h err %b lat 4", r, e, lat, erd2, eer2);
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] r;
        run_check(0, "pre_write_20", 32'h20, 1'b1, 2'b00, 1'b0, 32'hCAFE_F00D, r);
        set_req(0, 1'b1, 32'h20, 1'b1, 2'b00, 1'b0, 32'h1234_5678);
        @(posedge clk); #1;
        set_req(0, 1'b0, 32'h0, 1'b0, 2'b00, 1'b0, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checks++;
        if (rdy(0) !== 1'b0 || rv(0) !== 1'b0 || rd(0) !== 32'h0 || re(0) !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_wait: got ready=%b valid=%b rdata=%h err=%b, want 0 0 0 0",
                     rdy(0), rv(0), rd(0), re(0));
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        run_check(0, "read_20_after_reset", 32'h20, 1'b0, 2'b00, 1'b0, 32'h0, r);
        checks++;
        if (r !== 32'hCAFE_F00D) begin
            errors++; $display("FAIL reset_no_commit: got %h, want cafef00d", r);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r, erd;
        logic e, eer;
        int lat, waits;
        logic [31:0] r0;
        run_check(1, "w0_init0", 32'h0, 1'b1, 2'b00, 1'b0, 32'h8899_AABB, r0);
        run_check(1, "w0_init1", 32'h4, 1'b1, 2'b00, 1'b0, 32'h0123_F567, r0);
        for (int i = 0; i < 6; i++) begin
            logic [31:0] a;
            logic [1:0]  sz;
            logic        u;
            sz = 2'($urandom_range(0, 2));
            a  = 32'($urandom_range(0, 7));
            a  = (sz == 2'd0) ? (a & 32'hC) : (sz == 2'd1) ? (a & 32'hE) : a;
            u  = 1'($urandom);
            model_txn(1, a, 1'b0, sz, u, 32'h0, erd, eer);
            txn(1, a, 1'b0, sz, u, 32'h0, r, e, lat, waits);
            checks++;
            if (r !== erd || e !== eer || lat !== 2 || waits !== 0) begin
                errors++;
                $display("FAIL b2b_%0d addr=%h: got %h err %b lat %0d waits %0d, want %h err %b lat 2 waits 0",
                         i, a, r, e, lat, waits, erd, eer);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] r;
        for (int s = 0; s < 2; s++) begin
            for (int w = 0; w < 32; w++)
                run_check(s, "rand_init", 32'(w * 4), 1'b1, 2'b00, 1'b0, $urandom, r);
            for (int i = 0; i < 60; i++) begin
                logic [31:0] a;
                if ($urandom_range(0, 7) == 0) a = 32'h1000 + 32'($urandom_range(0, 255));
                else                           a = 32'($urandom_range(0, 127));
                run_check(s, "rand", a, 1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), $urandom, r);
            end
        end
    endtask

    initial begin
        set_req(0, 1'b0, 32'h0, 1'b0, 2'b00, 1'b0, 32'h0);
        set_req(1, 1'b0, 32'h0, 1'b0, 2'b00, 1'b0, 32'h0);
        set_rsp_ready(0, 1'b0);
        set_rsp_ready(1, 1'b0);
        test_reset();
        test_plan_directed();
        test_stall();
        test_reset_mid_wait();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
